// File: rtl/wb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_pkg
// Shared types for the bexkat1 Wishbone round-robin arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, OWN, DRAIN)
//   last_rst_value : reset value of the round-robin pointer for NM masters
// -----------------------------------------------------------------------------
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // The search starts one past the last owner, so parking the pointer on the
  // highest master makes master 0 the first winner after reset.
  function automatic int last_rst_value(input int nm);
    return nm - 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_rr_pick
// Combinational rotate-priority encoder. Returns the first asserted request
// at or after 'start', wrapping modulo NM.
//   req   in  NM          request vector
//   start in  $clog2(NM)  first index to consider
//   index out $clog2(NM)  chosen requester
//   valid out 1           any request present
// -----------------------------------------------------------------------------
module wb_rr_arbiter_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic [NM-1:0]         req,
  input  logic [$clog2(NM)-1:0] start,
  output logic [$clog2(NM)-1:0] index,
  output logic                  valid
);

  localparam int IW = $clog2(NM);
  localparam logic [IW:0] NM_W = (IW+1)'(NM);

  logic [2*NM-1:0] req_dbl;
  logic [NM-1:0]   rot_req;
  logic [IW-1:0]   offset;
  logic [IW:0]     sum;

  // Rotate so that bit 0 of rot_req is the request of master 'start'.
  assign req_dbl = {req, req};
  assign rot_req = NM'(req_dbl >> start);

  // Lowest set bit of the rotated vector wins; scan downwards so the last
  // assignment is the smallest offset.
  always_comb begin
    offset = '0;
    valid  = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        offset = IW'(i);
        valid  = 1'b1;
      end
    end
  end

  assign sum   = {1'b0, start} + {1'b0, offset};
  assign index = (sum >= NM_W) ? IW'(sum - NM_W) : IW'(sum);

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave among NM masters.
// A master owns the slave for its whole cyc envelope; outstanding strobes are
// counted so responses reach the issuing master and the slave is only handed
// over once every strobe has been answered.
//
// Parameters: NM (2..8), AW, DW, MAXOUT (power of two), TIMEOUT.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   m_cyc/m_stb/m_we [NM]            master controls
//   m_adr [NM*AW], m_dat_o [NM*DW]   master address / write data (k at k*W)
//   m_sel [NM*DW/8]                  master byte selects
//   m_dat_i [DW]                     read data to all masters
//   m_ack/m_err/m_stall [NM]         per-master responses
//   s_cyc/s_stb/s_we, s_adr, s_dat_o, s_sel   slave request side
//   s_dat_i, s_ack, s_err, s_stall   slave response side
//   grant [$clog2(NM)]               current owner (debug/trace)
// Build option: define WB_ARB_TIMEOUT_EN to add a no-response watchdog that
// errors the owner and returns to IDLE after TIMEOUT silent cycles.
// -----------------------------------------------------------------------------
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXOUT  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NM-1:0]         m_cyc,
  input  logic [NM-1:0]         m_stb,
  input  logic [NM-1:0]         m_we,
  input  logic [NM*AW-1:0]      m_adr,
  input  logic [NM*DW-1:0]      m_dat_o,
  input  logic [NM*DW/8-1:0]    m_sel,
  output logic [DW-1:0]         m_dat_i,
  output logic [NM-1:0]         m_ack,
  output logic [NM-1:0]         m_err,
  output logic [NM-1:0]         m_stall,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack,
  input  logic                  s_err,
  input  logic                  s_stall,
  output logic [$clog2(NM)-1:0] grant
);

  localparam int IW = $clog2(NM);
  localparam int CW = $clog2(MAXOUT) + 1;
  localparam int SW = DW / 8;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(last_rst_value(NM));
  localparam logic [IW-1:0] LAST_IDX = IW'(NM - 1);

  if (NM < 2 || NM > 8 || MAXOUT < 1 || (MAXOUT & (MAXOUT - 1)) != 0 ||
      TIMEOUT < 2 || (DW % 8) != 0) begin : g_bad_params
    $error("wb_rr_arbiter: parameter out of range");
  end

  arb_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [IW-1:0] last_reg, last_next;

  logic [IW-1:0] pick_start, pick_index;
  logic          pick_valid;
  logic          own, busy, cnt_full, cnt_zero;
  logic          stb_accept, resp_valid, expire;

  wb_rr_arbiter_rr_pick #(
    .NM(NM)
  ) u_rr_pick (
    .req  (m_cyc),
    .start(pick_start),
    .index(pick_index),
    .valid(pick_valid)
  );

  assign pick_start = (last_reg == LAST_IDX) ? '0 : last_reg + 1'b1;

  assign own      = (state_reg == OWN);
  assign busy     = (state_reg != IDLE);
  assign cnt_zero = (cnt_reg == '0);
  assign cnt_full = (cnt_reg == CNT_MAX);

  // Slave request side is a plain mux of the owner; controls are gated by
  // state so nothing leaks while idle or draining.
  assign s_cyc   = busy;
  assign s_stb   = own & m_cyc[grant_reg] & m_stb[grant_reg] & ~cnt_full;
  assign s_we    = own & m_we[grant_reg];
  assign s_adr   = m_adr[grant_reg*AW +: AW];
  assign s_dat_o = m_dat_o[grant_reg*DW +: DW];
  assign s_sel   = m_sel[grant_reg*SW +: SW];
  assign m_dat_i = s_dat_i;
  assign grant   = grant_reg;

  assign stb_accept = s_stb & ~s_stall;
  // A response with nothing outstanding is a slave protocol violation; it is
  // ignored so the counter cannot underflow.
  assign resp_valid = busy & (s_ack | s_err) & ~cnt_zero;

  for (genvar gi = 0; gi < NM; gi++) begin : g_resp
    logic sel;
    assign sel         = own & (grant_reg == IW'(gi));
    assign m_ack[gi]   = sel & s_ack & ~cnt_zero;
    assign m_err[gi]   = sel & ((s_err & ~cnt_zero) | expire);
    assign m_stall[gi] = ~sel | s_stall | cnt_full;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_reg, timer_next;

  // Counts consecutive silent cycles while strobes are outstanding; any
  // accepted strobe or response restarts the window.
  assign expire = busy & ~cnt_zero & ~stb_accept & ~resp_valid &
                  (timer_reg == TMO_LAST);

  always_comb begin
    timer_next = timer_reg + 1'b1;
    if (~busy | cnt_zero | stb_accept | resp_valid | expire) begin
      timer_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;

    if (stb_accept && !resp_valid) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!stb_accept && resp_valid) begin
      cnt_next = cnt_reg - 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_index;
          last_next  = pick_index;
          state_next = OWN;
        end
      end
      OWN: begin
        // The owner ending its cycle only releases the slave once nothing is
        // left in flight, counting a response arriving this same cycle.
        if (!m_cyc[grant_reg]) begin
          state_next = (cnt_next == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_next == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (expire) begin
      cnt_next   = '0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
      last_reg  <= LAST_RST;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Self-checking bench for wb_rr_arbiter (NM=4, MAXOUT=8, TIMEOUT=16).
// A behavioural slave answers accepted strobes after a programmable latency
// with data derived from the address; expected read data is queued when a
// master strobe is accepted and compared when m_ack returns.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXOUT = 8;
  localparam int TIMEOUT = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM*DW/8-1:0] m_sel;
  logic [DW-1:0]     m_dat_i;
  logic [NM-1:0]     m_ack, m_err, m_stall;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel;
  logic [DW-1:0]     s_dat_i = '0;
  logic              s_ack = 1'b0;
  logic              s_err = 1'b0;
  logic              s_stall = 1'b0;
  logic [1:0]        grant;

  wb_rr_arbiter #(
    .NM(NM), .AW(AW), .DW(DW), .MAXOUT(MAXOUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_o(m_dat_o), .m_sel(m_sel), .m_dat_i(m_dat_i),
    .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
    .grant(grant)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  always @(posedge clk_i) cyc_no <= cyc_no + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ---------------- behavioural slave ----------------
  typedef struct {int due; logic [31:0] data;} pend_t;
  pend_t pend_q[$];
  int  slv_lat = 2;
  bit  slv_silent = 1'b0;
  int  inj_seq = 0;
  int  inj_seen = 0;
  int  sack_cnt = 0;
  int  last_sack_cyc = -1;

  always @(posedge clk_i) begin
    bit          accepted;
    bit          inj;
    logic [31:0] a;
    accepted = s_cyc & s_stb & ~s_stall;
    a        = s_adr;
    inj      = (inj_seq != inj_seen);
    inj_seen = inj_seq;
    if (rst_i) pend_q.delete();
    else if (accepted && !slv_silent) pend_q.push_back('{cyc_no + slv_lat, slave_data(a)});
    #1;
    s_ack   = 1'b0;
    s_dat_i = 32'hDEAD_BEEF;
    if (inj && !rst_i) begin
      s_ack = 1'b1;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc_no) begin
      s_ack   = 1'b1;
      s_dat_i = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (s_ack) begin
      sack_cnt++;
      last_sack_cyc = cyc_no;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {int m; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  int   mack_cnt = 0;
  bit   err_expected = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    for (int k = 0; k < NM; k++) begin
      if (m_ack[k]) begin
        mack_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_ack", 32'(m_ack), 32'h0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] ack m%0d data %h (exp m%0d %h)", k, m_dat_i, e.m, e.d);
          check_eq("ack_master", 32'(k), 32'(e.m));
          check_eq("ack_data", m_dat_i, e.d);
        end
      end
    end
    if (m_err != '0 && !err_expected) check_eq("spurious_err", 32'(m_err), 32'h0);
  end

  // ---------------- master driver helpers ----------------
  int acc_cyc[16];
  int first_ack_cyc = -1;

  // Called and returns just after a rising edge.
  task automatic run_burst(input int m, input int n, input logic [31:0] base, input bit fwd);
    int  w;
    bit  done;
    for (int i = 0; i < n; i++) begin
      w = 0;
      done = 1'b0;
      m_stb[m] = 1'b1;
      m_adr[m*AW +: AW] = base + 32'(4 * i);
      while (!done) begin
        @(negedge clk_i);
        if (m_ack[m] && first_ack_cyc < 0) first_ack_cyc = cyc_no;
        if (!m_stall[m]) begin
          acc_cyc[i] = cyc_no;
          if (fwd) exp_q.push_back('{m, slave_data(base + 32'(4 * i))});
          $display("[TB] strobe m%0d adr %h cycle %0d", m, base + 32'(4 * i), cyc_no);
          done = 1'b1;
        end else if (++w > 200) begin
          check_eq("burst_stall_bound", 32'(w), 32'h0);
          done = 1'b1;
        end
        @(posedge clk_i); #1;
      end
    end
    m_stb[m] = 1'b0;
  endtask

  task automatic wait_mack(input int target, input string tag);
    int w;
    w = 0;
    while (mack_cnt < target && w < 100) begin
      @(posedge clk_i); #1;
      w++;
    end
    check_eq(tag, 32'(mack_cnt), 32'(target));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  int exp_rot[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    int mbase, sbase, g, w;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_o = '0; m_sel = '1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check_eq("rst_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_s_stb", 32'(s_stb), 32'h0);
    check_eq("rst_s_we", 32'(s_we), 32'h0);
    check_eq("rst_m_stall", 32'(m_stall), 32'hF);
    check_eq("rst_m_ack", 32'(m_ack), 32'h0);
    check_eq("rst_m_err", 32'(m_err), 32'h0);
    check_eq("rst_grant", 32'(grant), 32'h0);

    // Single master 2: grant latency, four reads, s_cyc release
    slv_lat = 2;
    @(posedge clk_i); #1;
    m_dat_o[2*DW +: DW] = 32'hCAFE_0002;
    m_cyc[2] = 1'b1;
    @(negedge clk_i);
    check_eq("t1_idle_cycle0", 32'(s_cyc), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("t1_grant", 32'(grant), 32'h2);
    check_eq("t1_s_cyc", 32'(s_cyc), 32'h1);
    check_eq("t1_s_dat_o", s_dat_o, 32'hCAFE_0002);
    check_eq("t1_s_sel", 32'(s_sel), 32'hF);
    @(posedge clk_i); #1;
    mbase = mack_cnt;
    run_burst(2, 4, 32'h0000_0100, 1'b1);
    wait_mack(mbase + 4, "t1_ack_count");
    m_cyc[2] = 1'b0;
    @(negedge clk_i);
    check_eq("t1_scyc_hold", 32'(s_cyc), 32'h1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("t1_scyc_fall", 32'(s_cyc), 32'h0);
    @(posedge clk_i); #1;

    // Rotation among masters 0, 1, 3
    do_reset();
    m_cyc = 4'b1011;
    @(posedge clk_i); #1;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk_i);
      check_eq("rot_grant", 32'(grant), 32'(exp_rot[r]));
      check_eq("rot_own", 32'(s_cyc), 32'h1);
      g = int'(grant);
      @(posedge clk_i); #1;
      m_cyc[g] = 1'b0;
      @(posedge clk_i); #1;
      m_cyc[g] = 1'b1;
      @(negedge clk_i);
      check_eq("rot_gap", 32'(s_cyc), 32'h0);
      @(posedge clk_i); #1;
    end
    m_cyc = '0;

    // MAXOUT limit with 12-cycle ack latency
    do_reset();
    slv_lat = 12;
    first_ack_cyc = -1;
    mbase = mack_cnt;
    m_cyc[0] = 1'b1;
    run_burst(0, 9, 32'h0000_1000, 1'b1);
    check_eq("max_back_to_back", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
    check_eq("max_8_before_ack", 32'(acc_cyc[7] < first_ack_cyc), 32'h1);
    check_eq("max_9th_resume", 32'(acc_cyc[8]), 32'(first_ack_cyc + 1));
    wait_mack(mbase + 9, "max_ack_count");
    m_cyc[0] = 1'b0;
    @(posedge clk_i); #1;

    // Abandoned cycle drains three acks without forwarding them
    do_reset();
    slv_lat = 6;
    mbase = mack_cnt;
    m_cyc[1] = 1'b1;
    run_burst(1, 3, 32'h0000_2000, 1'b0);
    sbase = sack_cnt;
    m_cyc[1] = 1'b0;
    m_cyc[0] = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("drain_s_cyc", 32'(s_cyc), 32'h1);
    check_eq("drain_s_stb", 32'(s_stb), 32'h0);
    check_eq("drain_grant_held", 32'(grant), 32'h1);
    w = 0;
    while (!(s_cyc && grant == 2'd0) && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    check_eq("drain_acks", 32'(sack_cnt - sbase), 32'd3);
    check_eq("drain_regrant_cycle", 32'(cyc_no), 32'(last_sack_cyc + 2));
    check_eq("drain_no_mack", 32'(mack_cnt), 32'(mbase));
    @(posedge clk_i); #1;

    // Stray ack with nothing outstanding
    do_reset();
    m_cyc[3] = 1'b1;
    @(posedge clk_i); #1;
    inj_seq++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("inj_sack_seen", 32'(s_ack), 32'h1);
    check_eq("inj_no_mack", 32'(m_ack), 32'h0);
    @(posedge clk_i); #1;
    m_cyc[3] = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("inj_no_underflow", 32'(s_cyc), 32'h0);
    @(posedge clk_i); #1;

    // Reset while five strobes are outstanding
    do_reset();
    slv_lat = 40;
    m_cyc[2] = 1'b1;
    run_burst(2, 5, 32'h0000_3000, 1'b0);
    rst_i = 1'b1;
    m_cyc = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_mid_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_mid_m_stall", 32'(m_stall), 32'hF);
    check_eq("rst_mid_grant", 32'(grant), 32'h0);
    @(posedge clk_i); #1;
    slv_lat = 2;
    mbase = mack_cnt;
    m_cyc[1] = 1'b1;
    run_burst(1, 1, 32'h0000_4000, 1'b1);
    wait_mack(mbase + 1, "rst_after_ack");
    m_cyc[1] = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("rst_cnt_clean", 32'(s_cyc), 32'h0);
    @(posedge clk_i); #1;

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave triggers the watchdog
    do_reset();
    slv_silent = 1'b1;
    err_expected = 1'b1;
    m_cyc[0] = 1'b1;
    run_burst(0, 1, 32'h0000_5000, 1'b0);
    w = 0;
    @(negedge clk_i);
    while (!m_err[0] && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    check_eq("to_err_cycle", 32'(cyc_no), 32'(acc_cyc[0] + TIMEOUT));
    m_cyc[0] = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("to_idle", 32'(s_cyc), 32'h0);
    check_eq("to_err_pulse", 32'(m_err), 32'h0);
    @(posedge clk_i); #1;
    slv_silent = 1'b0;
    err_expected = 1'b0;
`endif

    check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter that shares one pipelined Wishbone slave port among NM master ports in the bexkat1 memory subsystem. It supersedes fixed-priority instruction/data muxing when more requesters are added (DMA, debug, video). A master is granted for a whole bus cycle (`cyc` envelope). The arbiter counts outstanding strobes so that every ack and err returns to the master that issued the request, and so that the slave is never re-granted mid-flight.

## Interface
Parameters:
- NM, 4, number of master ports (2..8)
- AW, 32, address width
- DW, 32, data width
- MAXOUT, 8, maximum outstanding un-acked strobes per grant (power of two)
- TIMEOUT, 1024, watchdog cycles without ack before forced error (only with WB_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- m_cyc, m_stb, m_we  in  NM  per-master Wishbone controls
- m_adr  in  NM*AW  per-master address, master k at [k*AW +: AW]
- m_dat_o  in  NM*DW  per-master write data
- m_sel  in  NM*DW/8  per-master byte selects
- m_dat_i  out  DW  read data, shared by all masters
- m_ack, m_err, m_stall  out  NM  per-master responses
- s_cyc, s_stb, s_we  out  1  slave controls
- s_adr  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel  out  DW/8  slave byte selects
- s_dat_i  in  DW  slave read data
- s_ack, s_err, s_stall  in  1  slave responses
- grant  out  $clog2(NM)  current owner, for debug/trace

## Operation
- FSM states: IDLE, OWN, DRAIN.
- IDLE: if any `m_cyc` is high, pick a requester with rr_pick, starting the search at `last+1` (mod NM). Register the pick in `grant` and `last`, then go to OWN. With no request, stay in IDLE and hold `s_cyc` at 0.
- OWN: slave signals are a mux of master `grant`. `s_cyc`=1. `s_stb` = `m_stb[grant]` & ~`cnt_full`.
  - `cnt` increments on `s_stb & ~s_stall`.
  - `cnt` decrements on `s_ack | s_err`.
  - Simultaneous increment and decrement leave `cnt` unchanged.
  - `cnt_full` = (`cnt` == MAXOUT).
  - `m_ack[grant]` = `s_ack`, `m_err[grant]` = `s_err`. All other ack/err bits are 0.
- OWN exit: when `m_cyc[grant]` falls:
  - `cnt`==0 (or reaching 0 this cycle) → IDLE.
  - Otherwise → DRAIN.
- DRAIN: `s_cyc`=1, `s_stb`=0. Incoming acks/errs decrement `cnt` and are not forwarded (the master has abandoned the cycle). At `cnt`==0 → IDLE.
- Stall: `m_stall[k]` = 1 for k≠grant, and 1 for every k when not in OWN. `m_stall[grant]` = `s_stall | cnt_full`.
- `m_dat_i` = `s_dat_i` unconditionally.
- Ack/err arriving with `cnt`==0 (protocol violation): drop it, and leave `cnt` at 0 (no underflow).

## Timing
- Reset values: state IDLE, `cnt`=0, `grant`=0, `last`=NM-1 (so master 0 wins first). All `s_*` controls 0; `m_ack`/`m_err` 0; `m_stall` all 1.
- Grant latency: `m_cyc` rises in cycle N. Grant is registered at edge N+1. The first `s_stb` can be presented in cycle N+1.
- Arbitration gap: at least one IDLE cycle between owners. `s_cyc` drops for that cycle.
- Ack forwarding is combinational, with zero added latency.
- Reset asserted mid-cycle: everything returns to reset values at the next edge. In-flight acks are discarded.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A TIMEOUT-cycle counter runs in OWN/DRAIN while `cnt`>0. It reloads on every ack/err or accepted strobe.
  - On expiry in OWN, pulse `m_err[grant]` for one cycle.
  - On expiry in any state, force `cnt`=0, deassert `s_cyc`, and go to IDLE.
- Not defined: no counter exists. A silent slave hangs the arbiter in OWN/DRAIN indefinitely.

## Structure
- The shared bexkat1 package holds the FSM state enum `arb_state_t` and the reset constant for `last`.
- One sub-module, `rr_pick`: a combinational rotate-priority encoder.
  - Inputs: req[NM], start index.
  - Outputs: index, valid.

## Test plan
- Single master 2 requests `cyc` in cycle 0 → `grant`=2 at edge 1. Four back-to-back reads with a 2-cycle slave latency → four `m_ack[2]` pulses, in order, with correct data. `s_cyc` falls 1 cycle after `m_cyc[2]`.
- Masters 0, 1 and 3 all holding `cyc` continuously → grants rotate 0, 1, 3, 0, 1, 3 with one IDLE gap each. No master is granted twice in a row.
- Slave never stalls, acks delayed 12 cycles, MAXOUT=8 → exactly 8 strobes accepted, then `m_stall[grant]`=1 until the first ack, then one more strobe is accepted.
- Master drops `cyc` with `cnt`=3 → DRAIN. The 3 acks are not seen on any `m_ack`. IDLE follows the third ack, and the next requester is granted.
- Inject `s_ack` with `cnt`=0 → no `m_ack`, `cnt` stays 0. Assert `rst_i` in OWN with `cnt`=5 → IDLE, `cnt`=0, `m_stall`=all 1 next cycle.
- WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave silent after one strobe → `m_err[grant]` pulses at the 16th cycle, then IDLE with `s_cyc`=0.
